// File: rtl/ex_muldiv_if.sv
// Request/response channel between the EX stage and the iterative M-extension unit.
// Signal suffixes are named from the unit's point of view.
interface ex_muldiv_if #(
   parameter int XLEN = 32
) ();

   logic            req_valid_i;
   logic            req_ready_o;
   logic [2:0]      op_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            resp_valid_o;
   logic            resp_ready_i;
   logic [XLEN-1:0] res_o;

   modport slave (
      input  req_valid_i, op_i, rs1_i, rs2_i, resp_ready_i,
      output req_ready_o, resp_valid_o, res_o
   );

   modport master (
      output req_valid_i, op_i, rs1_i, rs2_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, res_o
   );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32/64 M-extension unit: one shift/add or restoring-divide step per cycle
// on latched operand magnitudes, with the sign fix applied when the result is registered.
module ex_muldiv #(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   output logic        busy_o,
   ex_muldiv_if.slave  bus
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            r_state, w_stateNext;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_absA, r_absB, r_specRes, r_res;
   logic              r_negQ, r_negR, r_special;
   logic [CW-1:0]     r_cnt;
   logic [2*XLEN-1:0] r_acc;

   logic              w_ready, w_accept, w_last, w_isDiv;
   logic              w_sgnA, w_sgnB, w_sA, w_sB, w_bZero, w_ovf, w_special;
   logic [XLEN-1:0]   w_absA, w_absB, w_specRes;
   logic [XLEN:0]     w_mulSum, w_remShift;
   logic [XLEN-1:0]   w_remSub, w_quot, w_rem, w_final;
   logic [2*XLEN-1:0] w_mulNext, w_divNext, w_accNext, w_prod;

   assign w_ready          = (r_state == IDLE) & ~flush_i & ~rst_i;
   assign w_accept         = bus.req_valid_i & w_ready;
   assign w_last           = (r_cnt == CW'(XLEN - 1));
   assign bus.req_ready_o  = w_ready;
   assign bus.resp_valid_o = (r_state == DONE);
   assign bus.res_o        = r_res;
   assign busy_o           = (r_state != IDLE);

   // Operand decode at accept: signedness, magnitudes, and the RISC-V divide corner cases
   always_comb begin
      w_isDiv   = bus.op_i[2];
      w_sgnA    = w_isDiv ? ~bus.op_i[0] : (bus.op_i != 3'd3);
      w_sgnB    = w_isDiv ? ~bus.op_i[0] : ~bus.op_i[1];
      w_sA      = w_sgnA & bus.rs1_i[XLEN-1];
      w_sB      = w_sgnB & bus.rs2_i[XLEN-1];
      w_absA    = w_sA ? -bus.rs1_i : bus.rs1_i;
      w_absB    = w_sB ? -bus.rs2_i : bus.rs2_i;
      w_bZero   = (bus.rs2_i == '0);
      w_ovf     = w_isDiv & ~bus.op_i[0] & (bus.rs1_i == MIN_INT) & (bus.rs2_i == '1);
      w_special = w_isDiv & (w_bZero | w_ovf);
      if (w_bZero)
         w_specRes = bus.op_i[1] ? bus.rs1_i : '1;
      else
         w_specRes = bus.op_i[1] ? '0 : bus.rs1_i;
   end

   // One iteration step; the mul accumulator keeps the unconsumed multiplier in its low half
   always_comb begin
      w_mulSum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_absA};
      w_mulNext  = r_acc[0] ? {w_mulSum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
      w_remShift = r_acc[2*XLEN-1:XLEN-1];
      w_remSub   = w_remShift[XLEN-1:0] - r_absB;
      if (w_remShift >= {1'b0, r_absB})
         w_divNext = {w_remSub, r_acc[XLEN-2:0], 1'b1};
      else
         w_divNext = {w_remShift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      w_accNext  = r_op[2] ? w_divNext : w_mulNext;
      w_prod     = r_negQ ? -w_accNext : w_accNext;
      w_quot     = r_negQ ? -w_accNext[XLEN-1:0] : w_accNext[XLEN-1:0];
      w_rem      = r_negR ? -w_accNext[2*XLEN-1:XLEN] : w_accNext[2*XLEN-1:XLEN];
      if (r_op[2])
         w_final = r_op[1] ? w_rem : w_quot;
      else
         w_final = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_stateNext;
   end

   // A flush wins in every state; in DONE with resp_ready_i high it coincides with the handshake
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_stateNext = (EARLY_OUT && w_special) ? DONE : CALC;
         CALC:    if (w_last) w_stateNext = DONE;
         DONE:    if (bus.resp_ready_i) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
      if (flush_i) w_stateNext = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_op      <= '0;
         r_absA    <= '0;
         r_absB    <= '0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
         r_special <= 1'b0;
         r_specRes <= '0;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_res     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op      <= bus.op_i;
                  r_absA    <= w_absA;
                  r_absB    <= w_absB;
                  r_negQ    <= w_sA ^ w_sB;
                  r_negR    <= w_sA;
                  r_special <= w_special;
                  r_specRes <= w_specRes;
                  r_cnt     <= '0;
                  r_acc     <= w_isDiv ? {{XLEN{1'b0}}, w_absA} : {{XLEN{1'b0}}, w_absB};
                  if (EARLY_OUT && w_special) r_res <= w_specRes;
               end
            end
            CALC: begin
               r_acc <= w_accNext;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) r_res <= r_special ? r_specRes : w_final;
            end
            default: ;
         endcase
      end
   end

endmodule
